fsm_flow_ctrl_n: RTL
====================

FSM_FLOW_CTRL_N -- requirements
Module: fsm_flow_ctrl_n

Interface
REQ-001 The module SHALL have parameter NUM_FIFOS, default 5: number of monitored FIFOs (main, VC0, VC1, D0, D1).
REQ-002 The module SHALL have parameter TW, default 5: width of each threshold.
REQ-003 The module SHALL have port clk  input  1  the single clock; all state changes on posedge.
REQ-004 The module SHALL have port reset  input  1  synchronous active-high reset.
REQ-005 The module SHALL have port init  input  1  request to enter and hold the INIT state.
REQ-006 The module SHALL have port thresh_low_in  input  NUM_FIFOS*TW  packed low thresholds, FIFO i at bits [i*TW +: TW].
REQ-007 The module SHALL have port thresh_high_in  input  NUM_FIFOS*TW  packed high thresholds, same packing.
REQ-008 The module SHALL have port fifo_empty  input  NUM_FIFOS  per-FIFO empty flags.
REQ-009 The module SHALL have port fifo_error  input  NUM_FIFOS  per-FIFO error flags.
REQ-010 The module SHALL have port state  output  3  current state encoding.
REQ-011 The module SHALL have port idle_out  output  1  high iff state is IDLE.
REQ-012 The module SHALL have port active_out  output  1  high iff state is ACTIVE.
REQ-013 The module SHALL have port error_out  output  1  high iff state is ERROR.
REQ-014 The module SHALL have port thresh_low_out  output  NUM_FIFOS*TW  registered low thresholds.
REQ-015 The module SHALL have port thresh_high_out  output  NUM_FIFOS*TW  registered high thresholds.
REQ-016 The module SHALL have port error_vec  output  NUM_FIFOS  sticky per-FIFO error record.

Function
REQ-017 States SHALL be encoded RESET=0, INIT=1, IDLE=2, ACTIVE=3, ERROR=4; values 5-7 SHALL go to RESET next cycle.
REQ-018 idle_out, active_out, error_out SHALL decode the state register combinationally, with no extra latency.
REQ-019 Transition priority SHALL be: reset, then any fifo_error bit, then init, then state-specific rules.
REQ-020 RESET SHALL go to INIT on the first posedge with reset low.
REQ-021 In INIT, thresh_low_out and thresh_high_out SHALL load the inputs at every posedge while state is INIT.
REQ-022 INIT SHALL be left to IDLE at the first posedge where init is low.
REQ-023 IDLE SHALL go to ACTIVE when any fifo_empty bit is low, and SHALL otherwise stay in IDLE.
REQ-024 ACTIVE SHALL go to IDLE when all fifo_empty bits are high, and SHALL otherwise stay in ACTIVE.
REQ-025 With init high in IDLE or ACTIVE, the next state SHALL be INIT; thresholds SHALL hold until loaded there.
REQ-026 Any fifo_error bit high in INIT, IDLE or ACTIVE SHALL move the state to ERROR at that posedge.
REQ-027 error_vec SHALL OR in fifo_error at every posedge outside RESET.
REQ-028 ERROR SHALL be sticky: only reset leaves it, and init is ignored there.
REQ-029 Thresholds SHALL hold outside INIT, and SHALL be compared unsigned, TW bits each.

Reset
REQ-030 At a posedge with reset high, from any state including mid-INIT or ERROR, state SHALL become RESET.
REQ-031 At that posedge thresh_low_out, thresh_high_out and error_vec SHALL clear to 0.
REQ-032 Reset SHALL take priority over init and fifo_error applied in the same cycle.

Configuration
REQ-033 With macro FSM_THRESH_CHECK_EN defined, leaving INIT SHALL go to ERROR instead of IDLE if any FIFO has registered low > high; error_vec SHALL set that FIFO's bit.
REQ-034 Without FSM_THRESH_CHECK_EN, INIT SHALL always exit to IDLE, and no comparator logic SHALL be built.

Verification
REQ-035 Bench SHALL hold reset high 2 cycles, then drop it with init=1 -> state RESET, then INIT one cycle later, with all outputs 0 during RESET.
REQ-036 Bench SHALL apply low=3/high=6 for FIFO0, drop init and hold all empties high -> thresholds latched, state IDLE, idle_out=1.
REQ-037 Bench SHALL clear fifo_empty[2] in IDLE, then set it high again -> ACTIVE next cycle, then IDLE next cycle.
REQ-038 Bench SHALL set fifo_error=5'b01000 in ACTIVE, then pulse init -> ERROR with error_vec=5'b01000, and state remains ERROR.
REQ-039 Bench SHALL assert reset while in ERROR -> RESET, with error_vec and thresholds cleared to 0.
REQ-040 With FSM_THRESH_CHECK_EN defined, bench SHALL set FIFO1 low=9/high=4 and exit INIT -> ERROR with error_vec=5'b00010; without the macro, the same stimulus SHALL give IDLE.

Source files
------------

// File: rtl/fsm_flow_ctrl_n.sv
// Flow-control FSM: monitors NUM_FIFOS FIFOs, latches per-FIFO thresholds in INIT, tracks sticky errors.
// Optional FSM_THRESH_CHECK_EN: leaving INIT with any registered low > high goes to ERROR.
module fsm_flow_ctrl_n #(
  parameter int NUM_FIFOS = 5,
  parameter int TW        = 5
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    init,
  input  logic [NUM_FIFOS*TW-1:0] thresh_low_in,
  input  logic [NUM_FIFOS*TW-1:0] thresh_high_in,
  input  logic [NUM_FIFOS-1:0]    fifo_empty,
  input  logic [NUM_FIFOS-1:0]    fifo_error,
  output logic [2:0]              state,
  output logic                    idle_out,
  output logic                    active_out,
  output logic                    error_out,
  output logic [NUM_FIFOS*TW-1:0] thresh_low_out,
  output logic [NUM_FIFOS*TW-1:0] thresh_high_out,
  output logic [NUM_FIFOS-1:0]    error_vec
);

  typedef enum logic [2:0] {
    S_RESET  = 3'd0,
    S_INIT   = 3'd1,
    S_IDLE   = 3'd2,
    S_ACTIVE = 3'd3,
    S_ERROR  = 3'd4
  } state_e;

  state_e                  state_q, state_d;
  logic [NUM_FIFOS*TW-1:0] thr_lo_q, thr_lo_d;
  logic [NUM_FIFOS*TW-1:0] thr_hi_q, thr_hi_d;
  logic [NUM_FIFOS-1:0]    err_vec_q, err_vec_d;
  logic [NUM_FIFOS-1:0]    thresh_bad;

`ifdef FSM_THRESH_CHECK_EN
  for (genvar i = 0; i < NUM_FIFOS; i++) begin : g_cmp
    assign thresh_bad[i] = thr_lo_q[i*TW +: TW] > thr_hi_q[i*TW +: TW];
  end
`else
  assign thresh_bad = '0;
`endif

  always_comb begin
    state_d   = state_q;
    thr_lo_d  = thr_lo_q;
    thr_hi_d  = thr_hi_q;
    err_vec_d = err_vec_q;
    if (state_q != S_RESET) err_vec_d = err_vec_q | fifo_error;
    if (state_q == S_INIT) begin
      thr_lo_d = thresh_low_in;
      thr_hi_d = thresh_high_in;
    end
    case (state_q)
      S_RESET: state_d = S_INIT;
      S_INIT: begin
        if (|fifo_error)     state_d = S_ERROR;
        else if (init)       state_d = S_INIT;
        else if (|thresh_bad) begin
          // checked against the thresholds already held, not the ones loading now
          state_d   = S_ERROR;
          err_vec_d = err_vec_d | thresh_bad;
        end
        else                 state_d = S_IDLE;
      end
      S_IDLE: begin
        if (|fifo_error)     state_d = S_ERROR;
        else if (init)       state_d = S_INIT;
        else if (!(&fifo_empty)) state_d = S_ACTIVE;
      end
      S_ACTIVE: begin
        if (|fifo_error)     state_d = S_ERROR;
        else if (init)       state_d = S_INIT;
        else if (&fifo_empty) state_d = S_IDLE;
      end
      S_ERROR: state_d = S_ERROR;
      default: state_d = S_RESET;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_RESET;
      thr_lo_q  <= '0;
      thr_hi_q  <= '0;
      err_vec_q <= '0;
    end else begin
      state_q   <= state_d;
      thr_lo_q  <= thr_lo_d;
      thr_hi_q  <= thr_hi_d;
      err_vec_q <= err_vec_d;
    end
  end

  assign state           = state_q;
  assign idle_out        = (state_q == S_IDLE);
  assign active_out      = (state_q == S_ACTIVE);
  assign error_out       = (state_q == S_ERROR);
  assign thresh_low_out  = thr_lo_q;
  assign thresh_high_out = thr_hi_q;
  assign error_vec       = err_vec_q;

endmodule
